// File: rtl/bin2bcd_arbiter_if.sv
// bin2bcd_arbiter_if
//   Bundles the request, converter and response signals of bin2bcd_arbiter.
//   The slave modport is the arbiter's view. The master modport is the view
//   of the surrounding logic: requesters, the shared converter and the
//   response consumer.
//
//   req_valid [NUM_REQ]            requester k presents an operand
//   req_bin   [NUM_REQ*BIN_WIDTH]  operand k at [k*BIN_WIDTH +: BIN_WIDTH]
//   req_ready [NUM_REQ]            one-hot accept strobe
//   conv_bin  [BIN_WIDTH]          operand driven to the external converter
//   conv_bcd  [4*BCD_DIGITS]       converter result
//   rsp_valid                      response available
//   rsp_id    [$clog2(NUM_REQ)]    requester the response belongs to
//   rsp_bcd   [4*BCD_DIGITS]       registered BCD result
//   rsp_ready                      response consumer accepts
//   busy                           arbiter not idle
interface bin2bcd_arbiter_if #(
  parameter int BIN_WIDTH  = 8,
  // Number of decimal digits of 2**BIN_WIDTH-1; 0.30103 approximates log10(2).
  parameter int BCD_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000,
  parameter int NUM_REQ    = 4
);
  localparam int BCD_WIDTH = 4 * BCD_DIGITS;
  localparam int ID_W      = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BIN_WIDTH-1:0] req_bin;
  logic [NUM_REQ-1:0]           req_ready;
  logic [BIN_WIDTH-1:0]         conv_bin;
  logic [BCD_WIDTH-1:0]         conv_bcd;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [BCD_WIDTH-1:0]         rsp_bcd;
  logic                         rsp_ready;
  logic                         busy;

  modport slave (
    input  req_valid, req_bin, conv_bcd, rsp_ready,
    output req_ready, conv_bin, rsp_valid, rsp_id, rsp_bcd, busy
  );

  modport master (
    output req_valid, req_bin, conv_bcd, rsp_ready,
    input  req_ready, conv_bin, rsp_valid, rsp_id, rsp_bcd, busy
  );
endinterface

// File: rtl/bin2bcd_arbiter.sv
// bin2bcd_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one external
//   binary-to-BCD converter. It serves one operand at a time:
//
//   IDLE     A requester is granted. The operand is latched into op_reg, which
//            drives the converter.
//   CONVERT  The block waits CONV_LAT cycles for the converter to settle. It
//            then samples the converter result.
//   RESP     The result is held on rsp_* until the consumer accepts it.
//
//   The round-robin pointer moves only when a response is accepted. A
//   requester that keeps requesting is therefore served after at most
//   NUM_REQ-1 other services.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    bin2bcd_arbiter_if.slave (request, converter and response signals)
module bin2bcd_arbiter #(
  parameter int BIN_WIDTH  = 8,
  // Number of decimal digits of 2**BIN_WIDTH-1; 0.30103 approximates log10(2).
  parameter int BCD_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000,
  parameter int NUM_REQ    = 4,
  parameter int CONV_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_arbiter_if.slave bus
);

  localparam int BCD_WIDTH = 4 * BCD_DIGITS;
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int CNT_W     = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_LAT - 1);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    RESP
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [ID_W-1:0]      rr_ptr_reg;
  logic [ID_W-1:0]      id_reg;
  logic [BIN_WIDTH-1:0] op_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BCD_WIDTH-1:0] rsp_bcd_reg;
  logic [ID_W-1:0]      rsp_id_reg;

  logic [BIN_WIDTH-1:0] req_op [NUM_REQ];
  logic [NUM_REQ-1:0]   req_win;
  logic [ID_W-1:0]      grant_off;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic                 xfer;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  // Doubling the vector before the shift makes the rotation wrap around.
  assign req_win = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_reg);

  // Find the first set bit of the rotated window. The loop runs downward so
  // that the lowest set offset is the last one assigned and therefore wins.
  always_comb begin
    grant_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_win[i]) begin
        grant_off = ID_W'(i);
      end
    end
  end

  // Convert the offset back to an absolute index, modulo NUM_REQ.
  assign grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= NUM_REQ_W) ? ID_W'(grant_sum - NUM_REQ_W)
                                              : grant_sum[ID_W-1:0];

  // A transfer happens only in IDLE, when some requester is valid and reset is
  // not asserted. Gating with rst_n keeps req_ready low throughout reset.
  assign xfer = rst_n && (state_reg == IDLE) && (|bus.req_valid);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_op[gi]        = bus.req_bin[gi*BIN_WIDTH +: BIN_WIDTH];
      assign bus.req_ready[gi] = xfer && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      id_reg      <= '0;
      op_reg      <= '0;
      cnt_reg     <= '0;
      rsp_bcd_reg <= '0;
      rsp_id_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            op_reg  <= req_op[grant_idx];
            id_reg  <= grant_idx;
            cnt_reg <= '0;
          end
        end
        CONVERT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // cnt_reg counts completed CONVERT cycles, so CNT_LAST marks the
          // CONV_LAT-th cycle. The converter has settled by then.
          if (cnt_reg == CNT_LAST) begin
            rsp_bcd_reg <= bus.conv_bcd;
            rsp_id_reg  <= id_reg;
          end
        end
        RESP: begin
          // The pointer moves past the requester just served, and only when
          // the consumer accepts the response.
          if (bus.rsp_ready) begin
            rr_ptr_reg <= (id_reg == LAST_ID) ? '0 : id_reg + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  assign bus.conv_bin  = op_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_bcd   = rsp_bcd_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bin2bcd_arbiter.sv
// tb_bin2bcd_arbiter
//   Bench for bin2bcd_arbiter with two instances.
//   dut_a  CONV_LAT=1, driven by a combinational converter model.
//   dut_b  CONV_LAT=3, driven by a converter model that needs two register
//          stages to settle, so sampling one cycle early returns stale data.
//   Expected grants come from a round-robin model. Expected BCD values come
//   from decimal arithmetic.
module tb_bin2bcd_arbiter;

  logic clk;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;
  int rr_model     = 0;

  logic [7:0]  ops_a [4];
  logic [11:0] b_s1;
  logic [11:0] b_s2;

  bin2bcd_arbiter_if #(.BIN_WIDTH(8), .BCD_DIGITS(3), .NUM_REQ(4)) ifa ();
  bin2bcd_arbiter_if #(.BIN_WIDTH(8), .BCD_DIGITS(3), .NUM_REQ(4)) ifb ();

  bin2bcd_arbiter #(
    .BIN_WIDTH(8), .BCD_DIGITS(3), .NUM_REQ(4), .CONV_LAT(1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  bin2bcd_arbiter #(
    .BIN_WIDTH(8), .BCD_DIGITS(3), .NUM_REQ(4), .CONV_LAT(3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v, one BCD nibble per digit.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Round-robin rule: the first valid requester at or after ptr, wrapping.
  function automatic int model_grant(input logic [3:0] m, input int ptr);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (((m >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pack_ops();
    return {ops_a[3], ops_a[2], ops_a[1], ops_a[0]};
  endfunction

  assign ifa.conv_bcd = to_bcd(int'(ifa.conv_bin));

  always_ff @(posedge clk) begin
    b_s1 <= to_bcd(int'(ifb.conv_bin));
    b_s2 <= b_s1;
  end
  assign ifb.conv_bcd = b_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction on dut_a. The caller has already driven req_valid and
  // req_bin and let them settle, with dut_a idle. The task returns in the
  // first IDLE cycle after the response has been accepted.
  task automatic serve_a(input int hold, input bit scramble,
                         output int g, output logic [11:0] seen_bcd, output int seen_id);
    logic [3:0]  mask;
    logic [7:0]  op;
    logic [11:0] eb;
    mask = ifa.req_valid;
    g    = model_grant(mask, rr_model);
    op   = ops_a[g[1:0]];
    eb   = to_bcd(int'(op));
    check("a.ready", 32'(ifa.req_ready), 32'(1) << g);
    tick();
    // CONVERT: rsp_ready and request changes here must have no effect.
    ifa.rsp_ready = 1'($urandom_range(0, 1));
    if (scramble) begin
      ifa.req_valid = 4'($urandom);
      ifa.req_bin   = $urandom;
    end
    #1;
    check("a.conv_busy", 32'(ifa.busy), 32'd1);
    check("a.conv_ready", 32'(ifa.req_ready), 32'd0);
    check("a.conv_bin", 32'(ifa.conv_bin), 32'(op));
    check("a.conv_valid", 32'(ifa.rsp_valid), 32'd0);
    tick();
    seen_bcd = ifa.rsp_bcd;
    seen_id  = int'(ifa.rsp_id);
    for (int h = 0; h < hold; h++) begin
      ifa.rsp_ready = 1'b0;
      #1;
      check("a.hold_valid", 32'(ifa.rsp_valid), 32'd1);
      check("a.hold_bcd", 32'(ifa.rsp_bcd), 32'(eb));
      check("a.hold_id", 32'(ifa.rsp_id), 32'(g));
      check("a.hold_ready", 32'(ifa.req_ready), 32'd0);
      tick();
    end
    ifa.rsp_ready = 1'b1;
    if (scramble) begin
      ifa.req_valid = mask;
      ifa.req_bin   = pack_ops();
    end
    #1;
    check("a.rsp_valid", 32'(ifa.rsp_valid), 32'd1);
    check("a.rsp_bcd", 32'(ifa.rsp_bcd), 32'(eb));
    check("a.rsp_id", 32'(ifa.rsp_id), 32'(g));
    check("a.rsp_busy", 32'(ifa.busy), 32'd1);
    tick();
    check("a.done_busy", 32'(ifa.busy), 32'd0);
    check("a.done_valid", 32'(ifa.rsp_valid), 32'd0);
    check("a.done_conv", 32'(ifa.conv_bin), 32'(op));
    rr_model = (g + 1) % 4;
    $display("[TB] txn A req=%0d op=%0d bcd=%03h hold=%0d", g, op, seen_bcd, hold);
  endtask

  initial begin
    int          g;
    int          sid;
    int          k;
    int          op;
    logic [11:0] bcd;
    logic [11:0] rr_bcd [5];
    int          rr_ord [5];

    rr_bcd = '{12'h010, 12'h020, 12'h030, 12'h040, 12'h010};
    rr_ord = '{0, 1, 2, 3, 0};
    ops_a  = '{8'd0, 8'd0, 8'd0, 8'd0};

    // Reset held with every requester valid.
    rst_n         = 1'b0;
    ifa.req_valid = 4'hF;
    ifa.req_bin   = 32'hFFFF_FFFF;
    ifa.rsp_ready = 1'b1;
    ifb.req_valid = 4'hF;
    ifb.req_bin   = 32'hFFFF_FFFF;
    ifb.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(ifa.req_ready), 32'd0);
    check("rst.busy", 32'(ifa.busy), 32'd0);
    check("rst.valid", 32'(ifa.rsp_valid), 32'd0);
    check("rst.conv", 32'(ifa.conv_bin), 32'd0);
    check("rst.bcd", 32'(ifa.rsp_bcd), 32'd0);
    check("rst.id", 32'(ifa.rsp_id), 32'd0);
    check("rst.b_ready", 32'(ifb.req_ready), 32'd0);

    ifa.req_valid = 4'h0;
    ifb.req_valid = 4'h0;
    rst_n         = 1'b1;
    tick();
    check("idle.busy", 32'(ifa.busy), 32'd0);
    check("idle.ready", 32'(ifa.req_ready), 32'd0);
    check("idle.conv", 32'(ifa.conv_bin), 32'd0);
    rr_model = 0;

    // Single request from requester 2.
    ops_a[2]      = 8'd255;
    ifa.req_bin   = pack_ops();
    ifa.req_valid = 4'b0100;
    #1;
    serve_a(0, 1'b0, g, bcd, sid);
    check("single.bcd", 32'(bcd), 32'h255);
    check("single.id", 32'(sid), 32'd2);
    ifa.req_valid = 4'h0;
    #1;

    // Reset during CONVERT aborts the operation.
    ops_a[3]      = 8'd77;
    ifa.req_bin   = pack_ops();
    ifa.req_valid = 4'b1000;
    #1;
    check("mrst.ready", 32'(ifa.req_ready), 32'h8);
    tick();
    check("mrst.busy", 32'(ifa.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst.ready_low", 32'(ifa.req_ready), 32'd0);
    check("mrst.busy_low", 32'(ifa.busy), 32'd0);
    check("mrst.valid", 32'(ifa.rsp_valid), 32'd0);
    check("mrst.bcd", 32'(ifa.rsp_bcd), 32'd0);
    check("mrst.conv", 32'(ifa.conv_bin), 32'd0);
    rst_n         = 1'b1;
    ifa.req_valid = 4'h0;
    rr_model      = 0;
    repeat (4) begin
      tick();
      check("mrst.after_busy", 32'(ifa.busy), 32'd0);
      check("mrst.after_valid", 32'(ifa.rsp_valid), 32'd0);
    end

    // Round robin with all four requesters valid throughout.
    ops_a         = '{8'd10, 8'd20, 8'd30, 8'd40};
    ifa.req_bin   = pack_ops();
    ifa.req_valid = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      serve_a(0, 1'b0, g, bcd, sid);
      check("rr.bcd", 32'(bcd), 32'(rr_bcd[n]));
      check("rr.order", 32'(sid), 32'(rr_ord[n]));
    end
    ifa.req_valid = 4'h0;
    #1;

    // Backpressure: response held for five cycles.
    ops_a[1]      = 8'd99;
    ifa.req_bin   = pack_ops();
    ifa.req_valid = 4'b0010;
    #1;
    serve_a(5, 1'b0, g, bcd, sid);
    check("bp.bcd", 32'(bcd), 32'h099);
    check("bp.id", 32'(sid), 32'd1);
    ifa.req_valid = 4'h0;
    #1;

    // Random contention, operands, hold times and request noise.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 4; r++) ops_a[r] = 8'($urandom);
      ifa.req_bin   = pack_ops();
      ifa.req_valid = 4'($urandom_range(1, 15));
      #1;
      serve_a(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, bcd, sid);
    end
    ifa.req_valid = 4'h0;
    #1;

    // Every 8-bit operand through requester 1.
    ifa.req_valid = 4'b0010;
    for (int v = 0; v < 256; v++) begin
      ops_a[1]    = 8'(v);
      ifa.req_bin = pack_ops();
      #1;
      serve_a(v % 2, 1'b0, g, bcd, sid);
    end
    ifa.req_valid = 4'h0;
    #1;

    // Latency with CONV_LAT=3 on dut_b.
    for (int n = 0; n < 6; n++) begin
      op = (n == 0) ? 128 : int'($urandom_range(0, 255));
      k  = int'($urandom_range(0, 3));
      ifb.req_bin   = 32'(op) << (8 * k);
      ifb.req_valid = 4'(1 << k);
      #1;
      check("lat.ready", 32'(ifb.req_ready), 32'(1) << k);
      tick();
      ifb.req_valid = 4'h0;
      ifb.rsp_ready = 1'b1;
      #1;
      for (int c = 1; c <= 3; c++) begin
        check("lat.early", 32'(ifb.rsp_valid), 32'd0);
        tick();
      end
      check("lat.valid", 32'(ifb.rsp_valid), 32'd1);
      check("lat.bcd", 32'(ifb.rsp_bcd), 32'(to_bcd(op)));
      check("lat.id", 32'(ifb.rsp_id), 32'(k));
      if (n == 0) check("lat.bcd128", 32'(ifb.rsp_bcd), 32'h128);
      $display("[TB] txn B req=%0d op=%0d bcd=%03h", k, op, ifb.rsp_bcd);
      tick();
      check("lat.done_busy", 32'(ifb.busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bin2bcd_arbiter.md
BIN2BCD_ARBITER -- requirements
Module: bin2bcd_arbiter

Interface
REQ-001 The block SHALL take parameter BIN_WIDTH, default 8, giving the binary operand width in bits.
REQ-002 The block SHALL take parameter BCD_DIGITS, default ceil(log10(2**BIN_WIDTH-1)), giving the number of BCD digits; BCD_WIDTH = 4*BCD_DIGITS.
REQ-003 The block SHALL take parameter NUM_REQ, default 4, range 2..8, giving the number of requesters.
REQ-004 The block SHALL take parameter CONV_LAT, default 1, range >=1, giving the converter settle cycles before sampling.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port req_valid, input, NUM_REQ bits: bit k high when requester k presents an operand.
REQ-008 Port req_bin, input, NUM_REQ*BIN_WIDTH bits: operand k at bits [k*BIN_WIDTH +: BIN_WIDTH].
REQ-009 Port req_ready, output, NUM_REQ bits: one-hot accept strobe per requester.
REQ-010 Port conv_bin, output, BIN_WIDTH bits: operand driven to the shared external binary-to-BCD converter.
REQ-011 Port conv_bcd, input, BCD_WIDTH bits: converter result.
REQ-012 Port rsp_valid, output, 1 bit: response available.
REQ-013 Port rsp_id, output, $clog2(NUM_REQ) bits: index of the requester the response belongs to.
REQ-014 Port rsp_bcd, output, BCD_WIDTH bits: registered BCD result.
REQ-015 Port rsp_ready, input, 1 bit: response consumer accepts.
REQ-016 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, CONVERT, RESP.
REQ-018 In IDLE with any req_valid set, the block SHALL grant g = first set bit of req_valid searching upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-019 req_ready SHALL be combinational, equal one-hot(g) only in IDLE with some req_valid set, and zero otherwise; a transfer occurs in that cycle.
REQ-020 On a transfer the block SHALL register op_reg <= operand g and id_reg <= g, clear the settle counter, and enter CONVERT.
REQ-021 conv_bin SHALL equal op_reg in all states; op_reg changes only on a transfer.
REQ-022 In CONVERT the counter SHALL increment each cycle; in the CONV_LAT-th CONVERT cycle the block SHALL capture rsp_bcd <= conv_bcd and rsp_id <= id_reg, and enter RESP.
REQ-023 Latency: transfer in cycle T SHALL give rsp_valid high from cycle T+CONV_LAT+1.
REQ-024 rsp_valid SHALL be high exactly in RESP; rsp_bcd and rsp_id SHALL hold stable while rsp_valid is high.
REQ-025 In RESP with rsp_ready high the block SHALL return to IDLE and set rr_ptr <= (id_reg+1) mod NUM_REQ; with rsp_ready low it SHALL stay in RESP indefinitely.
REQ-026 No new request SHALL be accepted in CONVERT or RESP, so back-to-back transfers are spaced at least CONV_LAT+2 cycles apart.
REQ-027 req_valid changes during CONVERT/RESP SHALL have no effect; a requester whose valid drops before grant is simply not served.
REQ-028 rsp_ready high outside RESP SHALL be ignored.
REQ-029 rr_ptr SHALL change only on response acceptance, so a continuously requesting requester waits at most NUM_REQ-1 other services.

Reset
REQ-030 With rst_n low at a clock edge, the block SHALL enter IDLE and set rr_ptr=0, op_reg=0, id_reg=0, counter=0, rsp_bcd=0, rsp_id=0.
REQ-031 During and after reset until the next transfer: rsp_valid=0, busy=0, conv_bin=0; req_ready SHALL be 0 while rst_n is low.
REQ-032 Reset asserted in CONVERT or RESP SHALL abort the operation with no response issued; the pending requester is not remembered.

Verification
REQ-033 Single request: BIN_WIDTH=8, CONV_LAT=1, requester 2 sends 8'd255, rsp_ready=1 -> req_ready=4'b0100 in cycle T, rsp_valid at T+2 with rsp_bcd=12'h255, rsp_id=2, busy low at T+3.
REQ-034 Round-robin: all four valid continuously with operands 10,20,30,40 -> grant order 0,1,2,3,0 with rsp_bcd 12'h010,12'h020,12'h030,12'h040.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP with operand 8'd99 -> rsp_valid, rsp_bcd=12'h099, rsp_id held constant, req_ready stays 0; completion one cycle after rsp_ready=1.
REQ-036 Latency: CONV_LAT=3, operand 8'd128 -> rsp_valid first high at T+4, rsp_bcd=12'h128.
REQ-037 Mid-operation reset: rst_n low for one cycle during CONVERT -> next cycle IDLE, rsp_valid=0, rsp_bcd=0, rr_ptr=0 (requester 0 wins next contention).
REQ-038 Exhaustive: sweep 0..255 via requester 1 -> every rsp_bcd matches the decimal digits of its operand.
